// File: rtl/lsu_mem.sv
// Load/store stage between the EX/LS and LS/WB pipeline registers: issues one
// word-aligned memory request per load/store, aligns load data and stalls EX until done.
module lsu_mem #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EX_LS_reg_execute_valid,
    input  logic [DATA_LEN-1:0] EX_LS_reg_dest_data,
    input  logic [DATA_LEN-1:0] EX_LS_reg_addr_load,
    input  logic [DATA_LEN-1:0] EX_LS_reg_store_data,
    input  logic [4:0]          EX_LS_reg_rd,
    input  logic                EX_LS_reg_dest_wen,
    input  logic [4:0]          EX_LS_reg_load_sign,
    input  logic [3:0]          EX_LS_reg_store_sign,
    input  logic                EX_LS_reg_unusual_flag,
    output logic                EX_reg_execute_enable,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [DATA_LEN-1:0] mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_LEN-1:0] mem_req_wdata,
    output logic [3:0]          mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_resp_rdata,
    output logic                LS_WB_reg_ls_valid,
    output logic [DATA_LEN-1:0] LS_WB_reg_dest_data,
    output logic [4:0]          LS_WB_reg_rd,
    output logic                LS_WB_reg_dest_wen,
    output logic                LS_WB_reg_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state, state_nxt;
    logic                is_load, is_store, is_half, is_word;
    logic                mem_op, misaligned, issue;
    logic [DATA_LEN-1:0] lane, load_data, wb_data;
    logic                wb_wen;
    logic                unused_store_sign;

    assign unused_store_sign = EX_LS_reg_store_sign[3];

    assign is_load    = |EX_LS_reg_load_sign;
    assign is_store   = |EX_LS_reg_store_sign[2:0];
    assign is_half    = EX_LS_reg_load_sign[2] | EX_LS_reg_load_sign[3] | EX_LS_reg_store_sign[1];
    assign is_word    = EX_LS_reg_load_sign[4] | EX_LS_reg_store_sign[2];
    assign mem_op     = EX_LS_reg_execute_valid & ~EX_LS_reg_unusual_flag & (is_load | is_store);
    assign misaligned = mem_op & ((is_half & EX_LS_reg_addr_load[0]) |
                                  (is_word & |EX_LS_reg_addr_load[1:0]));
    assign issue      = mem_op & ~misaligned;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: outputs get defaults before the case so no path can infer a latch.
    always_comb begin
        state_nxt             = state;
        mem_req_valid         = 1'b0;
        EX_reg_execute_enable = 1'b0;
        case (state)
            IDLE: begin
                EX_reg_execute_enable = ~issue;
                if (issue) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    EX_reg_execute_enable = 1'b1;
                    state_nxt             = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields come straight from EX/LS, which is frozen while the enable is low.
    assign mem_req_addr = {EX_LS_reg_addr_load[DATA_LEN-1:2], 2'b00};
    assign mem_req_wen  = is_store;

    always_comb begin
        mem_req_wmask = 4'b1111;
        mem_req_wdata = EX_LS_reg_store_data;
        if (EX_LS_reg_store_sign[0]) begin
            mem_req_wmask = 4'b0001 << EX_LS_reg_addr_load[1:0];
            mem_req_wdata = {(DATA_LEN/8){EX_LS_reg_store_data[7:0]}};
        end else if (EX_LS_reg_store_sign[1]) begin
            mem_req_wmask = 4'b0011 << EX_LS_reg_addr_load[1:0];
            mem_req_wdata = {(DATA_LEN/16){EX_LS_reg_store_data[15:0]}};
        end
    end

    assign lane = mem_resp_rdata >> {EX_LS_reg_addr_load[1:0], 3'b000};

    always_comb begin
        load_data = lane;
        if (EX_LS_reg_load_sign[0])      load_data = {{(DATA_LEN-8){lane[7]}}, lane[7:0]};
        else if (EX_LS_reg_load_sign[1]) load_data = {{(DATA_LEN-8){1'b0}}, lane[7:0]};
        else if (EX_LS_reg_load_sign[2]) load_data = {{(DATA_LEN-16){lane[15]}}, lane[15:0]};
        else if (EX_LS_reg_load_sign[3]) load_data = {{(DATA_LEN-16){1'b0}}, lane[15:0]};
    end

    // Only aligned loads write back a register among memory ops; traps never do.
    always_comb begin
        wb_data = EX_LS_reg_dest_data;
        wb_wen  = EX_LS_reg_execute_valid & EX_LS_reg_dest_wen & ~EX_LS_reg_unusual_flag;
        if (mem_op) begin
            wb_wen = 1'b0;
            if (is_load && !misaligned) begin
                wb_data = load_data;
                wb_wen  = EX_LS_reg_dest_wen;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LS_WB_reg_ls_valid  <= 1'b0;
            LS_WB_reg_dest_data <= '0;
            LS_WB_reg_rd        <= '0;
            LS_WB_reg_dest_wen  <= 1'b0;
            LS_WB_reg_misalign  <= 1'b0;
        end else if (EX_reg_execute_enable) begin
            LS_WB_reg_ls_valid  <= EX_LS_reg_execute_valid;
            LS_WB_reg_dest_data <= wb_data;
            LS_WB_reg_rd        <= EX_LS_reg_rd;
            LS_WB_reg_dest_wen  <= wb_wen;
            LS_WB_reg_misalign  <= misaligned;
        end
    end

endmodule
